// File: rtl/regbank_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package regbank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_NREG   = 8;
  localparam int DEF_DW     = 8;
  localparam int DEF_AW     = 3;
  localparam int MAX_ONEHOT = 256;

  // Out-of-range indices decode to all-zero so dropped writes touch nothing.
  function automatic logic [MAX_ONEHOT-1:0] onehot_dec(input logic [31:0] idx, input int n);
    logic [MAX_ONEHOT-1:0] r;
    r = '0;
    if (idx < $unsigned(n)) r = {{(MAX_ONEHOT-1){1'b0}}, 1'b1} << idx;
    return r;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// Combinational round-robin select: first set bit of req searching ptr, ptr+1, ... mod N.
module regbank_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        winner = IW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin write arbiter and clear sequencer for an enable-gated register bank.
// Optional requester lock when REGBANK_ARB_LOCK_EN is defined.
module regbank_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG,
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_data,
`ifdef REGBANK_ARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic [NREQ-1:0]         req_ready,
  output logic [NREG-1:0]         reg_en,
  output logic [DW-1:0]           reg_d,
  output logic                    reg_clr,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] pick_req;
  logic            accept;
  logic [AW-1:0]   win_addr;
  logic [IW-1:0]   ptr_nxt;
`ifdef REGBANK_ARB_LOCK_EN
  logic [IW-1:0]   owner;
`endif

  // While locked, only the owner is offered to the picker.
  always_comb begin
    pick_req = req_valid;
`ifdef REGBANK_ARB_LOCK_EN
    if (state == ST_LOCK) pick_req = req_valid & (NREQ'(1) << owner);
`endif
  end

  regbank_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req    (pick_req),
    .ptr    (ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  assign accept    = pick_any && !clr && (state != ST_INIT);
  assign req_ready = accept ? (NREQ'(1) << pick_idx) : '0;
  assign win_addr  = req_addr[pick_idx*AW +: AW];
  assign ptr_nxt   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  assign reg_clr   = (state == ST_INIT);
  assign busy      = (state != ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      ptr      <= '0;
      reg_en   <= '0;
      reg_d    <= '0;
      grant_id <= '0;
`ifdef REGBANK_ARB_LOCK_EN
      owner    <= '0;
`endif
    end else begin
      reg_en <= '0;
      if (accept) begin
        ptr      <= ptr_nxt;
        grant_id <= pick_idx;
        reg_d    <= req_data[pick_idx*DW +: DW];
        reg_en   <= NREG'(onehot_dec(32'(win_addr), NREG));
      end
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN: begin
          if (clr) begin
            state <= ST_INIT;
          end
`ifdef REGBANK_ARB_LOCK_EN
          else if (accept && req_lock[pick_idx]) begin
            state <= ST_LOCK;
            owner <= pick_idx;
          end
`endif
        end
`ifdef REGBANK_ARB_LOCK_EN
        ST_LOCK: begin
          if (clr)
            state <= ST_INIT;
          else if (!req_valid[owner] || (accept && !req_lock[pick_idx]))
            state <= ST_RUN;
        end
`endif
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: main instance (NREG=8) plus an NREG=6 copy for dropped writes.
module tb_regbank_arbiter;

  logic        clk;
  logic        reset;
  logic        clr;
  logic [3:0]  req_valid;
  logic [11:0] req_addr;
  logic [31:0] req_data;
`ifdef REGBANK_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic [3:0]  req_ready, req_ready6;
  logic [7:0]  reg_en;
  logic [5:0]  reg_en6;
  logic [7:0]  reg_d, reg_d6;
  logic        reg_clr, reg_clr6;
  logic [1:0]  grant_id, grant_id6;
  logic        busy, busy6;

  int tests;
  int fails;

  regbank_arbiter #(.NREQ(4), .NREG(8), .DW(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .clr(clr), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data),
`ifdef REGBANK_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .reg_en(reg_en), .reg_d(reg_d), .reg_clr(reg_clr),
    .grant_id(grant_id), .busy(busy)
  );

  regbank_arbiter #(.NREQ(4), .NREG(6), .DW(8), .AW(3)) dut6 (
    .clk(clk), .reset(reset), .clr(clr), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data),
`ifdef REGBANK_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready6), .reg_en(reg_en6), .reg_d(reg_d6), .reg_clr(reg_clr6),
    .grant_id(grant_id6), .busy(busy6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_slot(input int i, input logic [2:0] a, input logic [7:0] d);
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk); #1;
    tests++; if (reg_clr !== 1'b1) begin fails++; $display("FAIL rst_reg_clr: got %b want 1", reg_clr); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    tests++; if (reg_en !== 8'h00) begin fails++; $display("FAIL rst_reg_en: got %h want 00", reg_en); end
    tests++; if (reg_d !== 8'h00) begin fails++; $display("FAIL rst_reg_d: got %h want 00", reg_d); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (reg_clr !== 1'b1) begin fails++; $display("FAIL init_reg_clr: got %b want 1", reg_clr); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL init_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    tests++; if (reg_clr !== 1'b0) begin fails++; $display("FAIL run_reg_clr: got %b want 0", reg_clr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL run_busy: got %b want 0", busy); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL first_ready: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int exp_id [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] exp_rdy;
    logic [7:0] exp_en;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_slot(i, 3'(i), 8'h10 + 8'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 4'b0001 << exp_id[k];
      exp_en  = 8'b0000_0001 << exp_id[k];
      #1;
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      @(posedge clk); #1;
      tests++; if (grant_id !== 2'(exp_id[k])) begin fails++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_id, exp_id[k]); end
      tests++; if (reg_en !== exp_en) begin fails++; $display("FAIL rr_reg_en[%0d]: got %h want %h", k, reg_en, exp_en); end
      tests++; if (reg_d !== 8'h10 + 8'(exp_id[k])) begin fails++; $display("FAIL rr_reg_d[%0d]: got %h want %h", k, reg_d, 8'h10 + 8'(exp_id[k])); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_slot(2, 3'd3, 8'hA5);
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    tests++; if (reg_en !== 8'b0000_1000) begin fails++; $display("FAIL single_reg_en: got %b want 00001000", reg_en); end
    tests++; if (reg_d !== 8'hA5) begin fails++; $display("FAIL single_reg_d: got %h want a5", reg_d); end
    tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    @(posedge clk); #1;
    tests++; if (reg_en !== 8'h00) begin fails++; $display("FAIL single_pulse_end: got %b want 0", reg_en); end
  endtask

  task automatic test_addr_range();
    @(negedge clk);
    set_slot(3, 3'd7, 8'h5A);
    req_valid = 4'b1000;
    #1;
    tests++; if (req_ready6 !== 4'b1000) begin fails++; $display("FAIL oor_ready: got %b want 1000", req_ready6); end
    @(posedge clk); #1;
    tests++; if (reg_en6 !== 6'b000000) begin fails++; $display("FAIL oor_reg_en: got %b want 000000", reg_en6); end
    tests++; if (grant_id6 !== 2'd3) begin fails++; $display("FAIL oor_grant: got %0d want 3", grant_id6); end
    tests++; if (reg_d6 !== 8'h5A) begin fails++; $display("FAIL oor_reg_d: got %h want 5a", reg_d6); end
    tests++; if (reg_en !== 8'b1000_0000) begin fails++; $display("FAIL inrange_reg_en: got %b want 10000000", reg_en); end
    req_valid = 4'b1111;
    #1;
    tests++; if (req_ready6 !== 4'b0001) begin fails++; $display("FAIL oor_ptr_adv: got %b want 0001", req_ready6); end
    req_valid = 4'b0000;
  endtask

  task automatic test_clr();
    @(negedge clk);
    set_slot(0, 3'd0, 8'h33);
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL clr_pre_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    clr = 1'b1;
    req_valid = 4'b0011;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL clr_ready: got %b want 0000", req_ready); end
    tests++; if (reg_en !== 8'b0000_0001) begin fails++; $display("FAIL clr_pending_pulse: got %b want 00000001", reg_en); end
    @(posedge clk); #1;
    clr = 1'b0;
    tests++; if (reg_clr !== 1'b1) begin fails++; $display("FAIL clr_reg_clr: got %b want 1", reg_clr); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clr_busy: got %b want 1", busy); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL clr_init_ready: got %b want 0000", req_ready); end
    tests++; if (reg_en !== 8'h00) begin fails++; $display("FAIL clr_reg_en: got %b want 0", reg_en); end
    @(posedge clk); #1;
    tests++; if (reg_clr !== 1'b0) begin fails++; $display("FAIL clr_done: got %b want 0", reg_clr); end
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL clr_ptr_kept: got %b want 0010", req_ready); end
    req_valid = 4'b0000;
  endtask

`ifdef REGBANK_ARB_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    set_slot(1, 3'd5, 8'h77);
    req_valid = 4'b0111;
    req_lock  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL lock_ready[%0d]: got %b want 0010", k, req_ready); end
      @(posedge clk); #1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lock_busy[%0d]: got %b want 1", k, busy); end
    end
    req_valid = 4'b0101;
    req_lock  = 4'b0000;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL lock_exit_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lock_exit_busy: got %b want 0", busy); end
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL lock_next_grant: got %b want 0100", req_ready); end
    req_valid = 4'b0000;
  endtask
`endif

  task automatic test_reset_mid_pulse();
    @(negedge clk);
    set_slot(0, 3'd2, 8'hC3);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    tests++; if (reg_en !== 8'b0000_0100) begin fails++; $display("FAIL mid_pulse_setup: got %b want 00000100", reg_en); end
    reset = 1'b0;
    #1;
    tests++; if (reg_en !== 8'h00) begin fails++; $display("FAIL mid_rst_reg_en: got %b want 0", reg_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_rst_busy: got %b want 1", busy); end
    tests++; if (reg_d !== 8'h00) begin fails++; $display("FAIL mid_rst_reg_d: got %h want 00", reg_d); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_recover: got %b want 0", busy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    clr = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
`ifdef REGBANK_ARB_LOCK_EN
    req_lock = '0;
`endif
    test_reset();
    test_round_robin();
    test_single();
    test_addr_range();
    test_clr();
`ifdef REGBANK_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Round-robin write arbiter and sequencer for a bank of enable-gated D flip-flop registers, each with a synchronous clear. Up to NREQ requesters share one write port into NREG registers of DW bits. Per transfer, the block drives a one-hot per-register enable and a shared data bus. It also sequences the bank's synchronous clear after reset and on request.

## Interface
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of registers in the bank
- DW, 8, register data width
- AW, 3, address width, ≥ clog2(NREG)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clr  in  1  synchronous request to clear the whole bank
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed data; requester i at [i*DW +: DW]
- req_lock  in  NREQ  lock request; present only with REGBANK_ARB_LOCK_EN
- req_ready  out  NREQ  one-hot grant; transfer occurs when valid&ready at a rising edge
- reg_en  out  NREG  one-hot register enable into the bank
- reg_d  out  DW  shared data into the bank
- reg_clr  out  1  synchronous clear into the bank
- grant_id  out  clog2(NREQ)  index of the last accepted requester
- busy  out  1  high in INIT or LOCK

## Operation
- FSM states: INIT, RUN, and LOCK (LOCK exists only with the macro).
- Asynchronous reset forces INIT.
- INIT lasts exactly one cycle after reset release, then goes to RUN.
- reg_clr is high while state is INIT, so it is high during reset.
- req_ready is all-zero in INIT.
- In RUN, the winner is the first requester with req_valid set, searching ptr, ptr+1, … modulo NREQ.
  - req_ready[winner] is combinational from req_valid and the registered ptr.
- On an accepted transfer:
  - ptr becomes (winner+1) mod NREQ.
  - grant_id becomes winner.
  - reg_d becomes the winner's data.
  - reg_en becomes onehot(winner's addr).
- reg_en and reg_d are registered. reg_en is a single-cycle pulse; it returns to 0 on the next edge unless a new transfer is accepted.
- An address ≥ NREG is still accepted, and ptr still advances, but reg_en stays all-zero (the write is dropped).
- clr high in RUN or LOCK:
  - req_ready is all-zero that cycle.
  - The next state is INIT, giving one reg_clr cycle.
  - ptr is preserved.
  - Any pending reg_en pulse still completes.
- No req_valid: req_ready stays 0, ptr holds, reg_en is 0.
- Reset values: req_ready 0, reg_en 0, reg_d 0, grant_id 0, ptr 0, busy 1, reg_clr 1.

## Timing
- Transfer accepted at edge k → reg_en/reg_d valid during cycle k+1 → bank register q updates at edge k+1.
- Throughput: one transfer per cycle. Back-to-back grants to different requesters are allowed.
- Reset assertion clears all registered outputs immediately, even mid-pulse.
- Reset release: INIT for cycle 0, so the first grant is possible at the end of cycle 1.
- clr at edge k → reg_clr high during cycle k+1 → RUN from edge k+2.
- clr takes priority over grants in the same cycle.

## Configuration
- REGBANK_ARB_LOCK_EN defined:
  - The req_lock port and the LOCK state exist.
  - A transfer accepted with req_lock[winner]=1 enters LOCK, with owner = winner.
  - In LOCK only the owner can receive req_ready; other requesters wait.
  - LOCK exits to RUN on an owner transfer with req_lock=0, or on any cycle with req_valid[owner]=0.
  - ptr advances normally on exit.
- REGBANK_ARB_LOCK_EN undefined:
  - No req_lock port and no LOCK state.
  - busy is high only in INIT.

## Structure
- A shared package holds:
  - the FSM state enum (INIT, RUN, LOCK);
  - the default parameter constants;
  - a onehot-decode function.
- Sub-module rr_pick (combinational round-robin priority select, with req vector and ptr in, winner index and any-valid out) is natural, because LOCK reuses it with a masked request vector.
- The register bank itself is outside this block.

## Test plan
- Reset release with req_valid=4'b1111:
  - reg_clr high for one cycle after release and req_ready=0.
  - Then req_ready=4'b0001.
- Requester 2 alone, addr=3, data=8'hA5:
  - req_ready=4'b0100 in the same cycle.
  - Next cycle reg_en=8'b0000_1000, reg_d=8'hA5, grant_id=2.
  - The following cycle reg_en=0.
- All four requesters valid for 6 cycles: grant order is 0,1,2,3,0,1.
- clr=1 while req_valid=4'b0011:
  - No req_ready that cycle.
  - reg_clr high the next cycle.
  - Then a grant to the requester at ptr.
- With lock enabled, requester 1 lock=1 for 3 transfers while requesters 0 and 2 are valid:
  - Only requester 1 is granted for those 3 transfers.
  - Then requester 2 is granted next.
- Mid-operation and address edge cases:
  - Reset asserted while reg_en=8'b0000_0100: reg_en=0 immediately and busy=1.
  - NREG=6 with addr=7: transfer accepted and reg_en=0.
